// File: rtl/ddmm_calendar.sv
// Day-of-year calendar with BCD day/month/day-of-year readout and a binary year.
// Latency: one clock from a day tick or load to the registered doy. Date decode is combinational; there is no backpressure.
module ddmm_calendar #(
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned YEAR_INIT = 2000,
    parameter int unsigned LEAP_MODE = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        en,
    input  logic        load,
    input  logic [8:0]  load_doy,
    input  logic        leap_sw,
    output logic [3:0]  dd_msb,
    output logic [3:0]  dd_lsb,
    output logic [3:0]  mm_msb,
    output logic [3:0]  mm_lsb,
    output logic [11:0] doy_bcd,
    output logic [13:0] year,
    output logic        leap,
    output logic        year_wrap
);

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);
    localparam logic [13:0] YEAR_RST  = 14'(YEAR_INIT);
    // Days elapsed before each month in a common year.
    localparam logic [8:0] CUM [12] = '{9'd0, 9'd31, 9'd59, 9'd90, 9'd120, 9'd151,
                                        9'd181, 9'd212, 9'd243, 9'd273, 9'd304, 9'd334};

    logic [15:0] presc;
    logic [8:0]  doy;
    logic [13:0] year_q;
    logic [8:0]  last;
    logic        tick;

    always_comb begin
        if (LEAP_MODE == 1)
            leap = ((year_q % 14'd4) == 14'd0) &&
                   (((year_q % 14'd100) != 14'd0) || ((year_q % 14'd400) == 14'd0));
        else
            leap = leap_sw;
    end

    assign last = leap ? 9'd366 : 9'd365;
    assign tick = en && (presc == PRESC_MAX);
    assign year = year_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc     <= 16'd0;
            doy       <= 9'd1;
            year_q    <= YEAR_RST;
            year_wrap <= 1'b0;
        end else begin
            year_wrap <= 1'b0;
            if (load) begin
                presc <= 16'd0;
                if ((load_doy != 9'd0) && (load_doy <= last))
                    doy <= load_doy;
            end else if (tick) begin
                presc <= 16'd0;
                if (doy >= last) begin
                    doy       <= 9'd1;
                    year_q    <= (year_q == 14'd9999) ? 14'd0 : year_q + 14'd1;
                    year_wrap <= 1'b1;
                end else begin
                    doy <= doy + 9'd1;
                end
            end else if (en) begin
                presc <= presc + 16'd1;
            end
        end
    end

    // A stale doy of 366 after leap drops is shown as 31/12 until the wrap tick.
    logic [8:0] disp;
    logic [8:0] start;
    logic [8:0] s;
    logic [3:0] mon;
    logic [4:0] day;

    always_comb begin
        disp  = (doy > last) ? last : doy;
        start = 9'd0;
        mon   = 4'd1;
        s     = 9'd0;
        for (int i = 1; i < 12; i++) begin
            s = CUM[i] + ((leap && i >= 2) ? 9'd1 : 9'd0);
            if (disp > s) begin
                mon   = 4'(i + 1);
                start = s;
            end
        end
        day = 5'(disp - start);
    end

    assign dd_msb  = 4'(day / 5'd10);
    assign dd_lsb  = 4'(day % 5'd10);
    assign mm_msb  = (mon >= 4'd10) ? 4'd1 : 4'd0;
    assign mm_lsb  = (mon >= 4'd10) ? mon - 4'd10 : mon;
    assign doy_bcd = {4'(doy / 9'd100), 4'((doy / 9'd10) % 9'd10), 4'(doy % 9'd10)};

endmodule

// File: tb/tb_ddmm_calendar.sv
// Directed bench for ddmm_calendar across five parameterisations sharing one stimulus set.
module tb_ddmm_calendar;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       en;
    logic       load;
    logic [8:0] load_doy;
    logic       leap_sw;

    logic [3:0]  dd_msb [5];
    logic [3:0]  dd_lsb [5];
    logic [3:0]  mm_msb [5];
    logic [3:0]  mm_lsb [5];
    logic [11:0] doy_bcd [5];
    logic [13:0] year [5];
    logic        leap [5];
    logic        year_wrap [5];

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    // 0: defaults, 1: TICK_DIV=4, 2..4: computed leap from 1900, 2000, 9999.
    ddmm_calendar u_dut0 (.clock(clock), .reset_n(reset_n), .en(en), .load(load), .load_doy(load_doy),
        .leap_sw(leap_sw), .dd_msb(dd_msb[0]), .dd_lsb(dd_lsb[0]), .mm_msb(mm_msb[0]), .mm_lsb(mm_lsb[0]),
        .doy_bcd(doy_bcd[0]), .year(year[0]), .leap(leap[0]), .year_wrap(year_wrap[0]));
    ddmm_calendar #(.TICK_DIV(4)) u_dut1 (.clock(clock), .reset_n(reset_n), .en(en), .load(load),
        .load_doy(load_doy), .leap_sw(leap_sw), .dd_msb(dd_msb[1]), .dd_lsb(dd_lsb[1]), .mm_msb(mm_msb[1]),
        .mm_lsb(mm_lsb[1]), .doy_bcd(doy_bcd[1]), .year(year[1]), .leap(leap[1]), .year_wrap(year_wrap[1]));
    ddmm_calendar #(.LEAP_MODE(1), .YEAR_INIT(1900)) u_dut2 (.clock(clock), .reset_n(reset_n), .en(en),
        .load(load), .load_doy(load_doy), .leap_sw(leap_sw), .dd_msb(dd_msb[2]), .dd_lsb(dd_lsb[2]),
        .mm_msb(mm_msb[2]), .mm_lsb(mm_lsb[2]), .doy_bcd(doy_bcd[2]), .year(year[2]), .leap(leap[2]),
        .year_wrap(year_wrap[2]));
    ddmm_calendar #(.LEAP_MODE(1), .YEAR_INIT(2000)) u_dut3 (.clock(clock), .reset_n(reset_n), .en(en),
        .load(load), .load_doy(load_doy), .leap_sw(leap_sw), .dd_msb(dd_msb[3]), .dd_lsb(dd_lsb[3]),
        .mm_msb(mm_msb[3]), .mm_lsb(mm_lsb[3]), .doy_bcd(doy_bcd[3]), .year(year[3]), .leap(leap[3]),
        .year_wrap(year_wrap[3]));
    ddmm_calendar #(.LEAP_MODE(1), .YEAR_INIT(9999)) u_dut4 (.clock(clock), .reset_n(reset_n), .en(en),
        .load(load), .load_doy(load_doy), .leap_sw(leap_sw), .dd_msb(dd_msb[4]), .dd_lsb(dd_lsb[4]),
        .mm_msb(mm_msb[4]), .mm_lsb(mm_lsb[4]), .doy_bcd(doy_bcd[4]), .year(year[4]), .leap(leap[4]),
        .year_wrap(year_wrap[4]));

    // Date packed as DD/MM digits, e.g. 16'h3112 is 31/12.
    function automatic logic [15:0] dm(int k);
        return {dd_msb[k], dd_lsb[k], mm_msb[k], mm_lsb[k]};
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        en = 1'b0; load = 1'b0; load_doy = 9'd0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic do_load(logic [8:0] v);
        load = 1'b1; load_doy = v;
        step(1);
        load = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        vectors++;
        if (dm(0) !== 16'h0101) begin miscompares++; $display("FAIL reset_date got %h want 0101", dm(0)); end
        vectors++;
        if (doy_bcd[0] !== 12'h001) begin miscompares++; $display("FAIL reset_doy got %h want 001", doy_bcd[0]); end
        vectors++;
        if (year[0] !== 14'd2000 || year_wrap[0] !== 1'b0) begin
            miscompares++; $display("FAIL reset_year got %0d/%b want 2000/0", year[0], year_wrap[0]);
        end
        vectors++;
        if (year[2] !== 14'd1900) begin miscompares++; $display("FAIL reset_year_init got %0d want 1900", year[2]); end
    endtask

    task automatic test_count();
        pulse_reset();
        leap_sw = 1'b0;
        en = 1'b1;
        step(59);
        en = 1'b0;
        vectors++;
        if (doy_bcd[0] !== 12'h060) begin miscompares++; $display("FAIL count_doy got %h want 060", doy_bcd[0]); end
        vectors++;
        if (dm(0) !== 16'h0103) begin miscompares++; $display("FAIL count_date got %h want 0103", dm(0)); end
        vectors++;
        if (doy_bcd[1] !== 12'h015 || dm(1) !== 16'h1501) begin
            miscompares++; $display("FAIL count_div4 got %h %h want 015 1501", doy_bcd[1], dm(1));
        end
    endtask

    task automatic test_leap_feb();
        pulse_reset();
        leap_sw = 1'b1;
        do_load(9'd60);
        vectors++;
        if (dm(0) !== 16'h2902 || leap[0] !== 1'b1) begin
            miscompares++; $display("FAIL feb29 got %h leap %b want 2902 leap 1", dm(0), leap[0]);
        end
        leap_sw = 1'b0;
        #1;
        vectors++;
        if (dm(0) !== 16'h0103 || doy_bcd[0] !== 12'h060) begin
            miscompares++; $display("FAIL leap_drop_view got %h %h want 0103 060", dm(0), doy_bcd[0]);
        end
        leap_sw = 1'b1;
        en = 1'b1;
        step(1);
        en = 1'b0;
        vectors++;
        if (doy_bcd[0] !== 12'h061 || dm(0) !== 16'h0103) begin
            miscompares++; $display("FAIL feb29_tick got %h %h want 061 0103", doy_bcd[0], dm(0));
        end
        leap_sw = 1'b0;
        do_load(9'd366);
        vectors++;
        if (doy_bcd[0] !== 12'h061) begin miscompares++; $display("FAIL load366_common got %h want 061", doy_bcd[0]); end
        do_load(9'd0);
        vectors++;
        if (doy_bcd[0] !== 12'h061) begin miscompares++; $display("FAIL load0 got %h want 061", doy_bcd[0]); end
        leap_sw = 1'b1;
        do_load(9'd366);
        leap_sw = 1'b0;
        #1;
        vectors++;
        if (dm(0) !== 16'h3112 || doy_bcd[0] !== 12'h366) begin
            miscompares++; $display("FAIL stale366 got %h %h want 3112 366", dm(0), doy_bcd[0]);
        end
        en = 1'b1;
        step(1);
        en = 1'b0;
        vectors++;
        if (doy_bcd[0] !== 12'h001 || year[0] !== 14'd2001) begin
            miscompares++; $display("FAIL stale366_wrap got %h %0d want 001 2001", doy_bcd[0], year[0]);
        end
    endtask

    task automatic test_year_wrap();
        pulse_reset();
        leap_sw = 1'b0;
        do_load(9'd365);
        vectors++;
        if (dm(0) !== 16'h3112) begin miscompares++; $display("FAIL dec31 got %h want 3112", dm(0)); end
        en = 1'b1;
        step(1);
        en = 1'b0;
        vectors++;
        if (dm(0) !== 16'h0101 || year[0] !== 14'd2001 || year_wrap[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap got %h %0d %b want 0101 2001 1", dm(0), year[0], year_wrap[0]);
        end
        step(1);
        vectors++;
        if (year_wrap[0] !== 1'b0 || year[0] !== 14'd2001) begin
            miscompares++; $display("FAIL wrap_pulse got %b %0d want 0 2001", year_wrap[0], year[0]);
        end
    endtask

    task automatic test_leap_mode();
        pulse_reset();
        leap_sw = 1'b1;
        #1;
        vectors++;
        if (leap[2] !== 1'b0 || leap[3] !== 1'b1 || leap[4] !== 1'b0) begin
            miscompares++; $display("FAIL leap_calc got %b%b%b want 010", leap[2], leap[3], leap[4]);
        end
        do_load(9'd366);
        vectors++;
        if (doy_bcd[3] !== 12'h366 || dm(3) !== 16'h3112) begin
            miscompares++; $display("FAIL y2000_366 got %h %h want 366 3112", doy_bcd[3], dm(3));
        end
        vectors++;
        if (doy_bcd[2] !== 12'h001) begin miscompares++; $display("FAIL y1900_366 got %h want 001", doy_bcd[2]); end
        do_load(9'd365);
        en = 1'b1;
        step(1);
        en = 1'b0;
        vectors++;
        if (year[4] !== 14'd0 || doy_bcd[4] !== 12'h001 || year_wrap[4] !== 1'b1) begin
            miscompares++;
            $display("FAIL y9999_wrap got %0d %h %b want 0 001 1", year[4], doy_bcd[4], year_wrap[4]);
        end
        vectors++;
        if (leap[4] !== 1'b1) begin miscompares++; $display("FAIL y0_leap got %b want 1", leap[4]); end
    endtask

    task automatic test_prescaler();
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            en = (i % 2 == 0);
            step(1);
        end
        en = 1'b0;
        vectors++;
        if (doy_bcd[1] !== 12'h001) begin miscompares++; $display("FAIL div_3en got %h want 001", doy_bcd[1]); end
        en = 1'b1;
        step(1);
        vectors++;
        if (doy_bcd[1] !== 12'h002) begin miscompares++; $display("FAIL div_4en got %h want 002", doy_bcd[1]); end
        step(2);
        do_load(9'd10);
        step(3);
        vectors++;
        if (doy_bcd[1] !== 12'h010) begin miscompares++; $display("FAIL div_load_clr got %h want 010", doy_bcd[1]); end
        step(1);
        vectors++;
        if (doy_bcd[1] !== 12'h011) begin miscompares++; $display("FAIL div_after_load got %h want 011", doy_bcd[1]); end
        step(3);
        do_load(9'd100);
        vectors++;
        if (doy_bcd[1] !== 12'h100) begin miscompares++; $display("FAIL load_vs_tick got %h want 100", doy_bcd[1]); end
        step(3);
        en = 1'b0;
        vectors++;
        if (doy_bcd[1] !== 12'h100) begin miscompares++; $display("FAIL div_post_load got %h want 100", doy_bcd[1]); end
    endtask

    task automatic test_async_reset();
        pulse_reset();
        en = 1'b1;
        step(6);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (dm(0) !== 16'h0101 || doy_bcd[0] !== 12'h001 || year[0] !== 14'd2000) begin
            miscompares++;
            $display("FAIL async_reset got %h %h %0d want 0101 001 2000", dm(0), doy_bcd[0], year[0]);
        end
        #2;
        reset_n = 1'b1;
        step(1);
        en = 1'b0;
        vectors++;
        if (doy_bcd[0] !== 12'h002) begin miscompares++; $display("FAIL resume got %h want 002", doy_bcd[0]); end
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; load = 1'b0; load_doy = 9'd0; leap_sw = 1'b0;
        #12;
        reset_n = 1'b1;
        test_reset();
        test_count();
        test_leap_feb();
        test_year_wrap();
        test_leap_mode();
        test_prescaler();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
